cfg_cmd_parser: RTL and testbench

Upstream configuration master for the clock divider block. Takes bytes from the UART receiver and decodes 3-byte framed commands: header, data, checksum. Each valid command becomes one write on the divider's c_valid/c_addr/c_data/c_ready config port. Malformed, illegal or stalled commands are dropped and flagged.

---
 rtl/cfg_cmd_parser.sv | 140 ++++++++++++++
 tb/tb_cfg_cmd_parser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_cmd_parser.sv
// Decodes 3-byte {header, data, checksum} frames from the UART byte stream and
// issues each valid command as one write on the divider's valid/ready config port.
module cfg_cmd_parser #(
   parameter logic [3:0]  SYNC      = 4'hA,
   parameter logic [15:0] ADDR_MASK = 16'h0110,
   parameter int          TIMEOUT   = 50000,
   parameter int          TW        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       c_ready,
   output logic       c_valid,
   output logic [3:0] c_addr,
   output logic [7:0] c_data,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_code,
   output logic       ovr
);

   typedef enum logic [1:0] {IDLE, GET_DATA, GET_CSUM, ISSUE} state_t;

   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [7:0]    hdr_q, hdr_d, data_q, data_d;
   logic [3:0]    addr_q, addr_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          c_valid_d, busy_d, err_d, ovr_d;
   logic [3:0]    c_addr_d;
   logic [7:0]    c_data_d;
   logic [1:0]    err_code_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hdr_q    <= '0;
         data_q   <= '0;
         addr_q   <= '0;
         timer_q  <= '0;
         c_valid  <= 1'b0;
         c_addr   <= '0;
         c_data   <= '0;
         busy     <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
         ovr      <= 1'b0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         timer_q  <= timer_d;
         c_valid  <= c_valid_d;
         c_addr   <= c_addr_d;
         c_data   <= c_data_d;
         busy     <= busy_d;
         err      <= err_d;
         err_code <= err_code_d;
         ovr      <= ovr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      data_d     = data_q;
      addr_d     = addr_q;
      timer_d    = timer_q;
      c_valid_d  = c_valid;
      c_addr_d   = c_addr;
      c_data_d   = c_data;
      err_d      = 1'b0;
      err_code_d = 2'b00;
      ovr_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid && rx_data[7:4] == SYNC) begin
               hdr_d   = rx_data;
               addr_d  = rx_data[3:0];
               timer_d = '0;
               state_d = GET_DATA;
            end
         end
         GET_DATA: begin
            if (rx_valid) begin
               data_d  = rx_data;
               timer_d = '0;
               state_d = GET_CSUM;
            end
         end
         GET_CSUM: begin
            if (rx_valid) begin
               timer_d = '0;
               if (rx_data != (hdr_q ^ data_q)) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
                  state_d    = IDLE;
               end else if (!ADDR_MASK[addr_q]) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b10;
                  state_d    = IDLE;
               end else begin
                  c_valid_d = 1'b1;
                  c_addr_d  = addr_q;
                  c_data_d  = data_q;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            // the command is already captured, so any byte here is lost
            ovr_d = rx_valid;
            if (c_ready) begin
               c_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // inter-byte timer; a byte arriving in the expiry cycle wins
      if ((state_q == GET_DATA || state_q == GET_CSUM) && !rx_valid) begin
         if (timer_q == T_LAST) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
            timer_d    = '0;
            state_d    = IDLE;
         end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_cfg_cmd_parser.sv
// Bench for cfg_cmd_parser: directed frames plus random traffic, every cycle
// compared against a frame-level reference model.
module tb_cfg_cmd_parser;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic       c_ready = 1'b1;
   logic       c_valid, busy, err, ovr;
   logic [3:0] c_addr;
   logic [7:0] c_data;
   logic [1:0] err_code;

   cfg_cmd_parser #(.SYNC(4'hA), .ADDR_MASK(16'h0110), .TIMEOUT(TO), .TW(5)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .c_ready(c_ready),
      .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .busy(busy),
      .err(err), .err_code(err_code), .ovr(ovr)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   bit rand_mode = 0;

   // reference model: bytes of the frame collected so far, plus a pending write
   logic [7:0]  frame[$];
   int          gap;
   bit          pending;
   logic [3:0]  p_addr;
   logic [7:0]  p_data;
   logic [15:0] legal = 16'h0110;
   logic        e_err, e_ovr;
   logic [1:0]  e_code;

   task automatic model_step(input logic r, input logic rv, input logic [7:0] rd, input logic cr);
      e_err = 0; e_code = 0; e_ovr = 0;
      if (r) begin
         frame.delete(); gap = 0; pending = 0;
      end else if (pending) begin
         e_ovr = rv;
         if (cr) pending = 0;
      end else if (frame.size() == 0) begin
         if (rv && rd[7:4] == 4'hA) begin frame.push_back(rd); gap = 0; end
      end else if (rv) begin
         frame.push_back(rd); gap = 0;
         if (frame.size() == 3) begin
            if (frame[2] != (frame[0] ^ frame[1])) begin e_err = 1; e_code = 2'b01; end
            else if (!legal[frame[0][3:0]]) begin e_err = 1; e_code = 2'b10; end
            else begin pending = 1; p_addr = frame[0][3:0]; p_data = frame[1]; end
            frame.delete();
         end
      end else if (gap == TO - 1) begin
         e_err = 1; e_code = 2'b11; frame.delete(); gap = 0;
      end else begin
         gap++;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input logic rv, input logic [7:0] rd);
      if (rand_mode) begin
         c_ready = 1'($urandom_range(0, 1));
         rst     = ($urandom_range(0, 79) == 0);
      end
      rx_valid = rv;
      rx_data  = rd;
      @(posedge clk);
      model_step(rst, rv, rd, c_ready);
      @(negedge clk);
      rx_valid = 1'b0;
      chk("c_valid", 8'(c_valid), 8'(pending));
      chk("busy", 8'(busy), 8'(pending || frame.size() != 0));
      chk("err", 8'(err), 8'(e_err));
      chk("err_code", 8'(err_code), 8'(e_code));
      chk("ovr", 8'(ovr), 8'(e_ovr));
      if (pending) begin
         chk("c_addr", 8'(c_addr), 8'(p_addr));
         chk("c_data", c_data, p_data);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int sp);
      tick(1'b1, b0); idle(sp);
      tick(1'b1, b1); idle(sp);
      tick(1'b1, b2);
   endtask

   initial begin
      gap = 0; pending = 0; p_addr = 0; p_data = 0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;

      // single write with ready already high
      c_ready = 1'b1;
      send(8'hA4, 8'h04, 8'hA0, 10);
      idle(3);

      // held write under back-pressure
      c_ready = 1'b0;
      send(8'hA8, 8'h02, 8'hAA, 0);
      idle(9);
      c_ready = 1'b1;
      idle(3);

      // bad checksum, then recovery
      send(8'hA4, 8'h04, 8'h00, 0);
      idle(2);
      send(8'hA4, 8'h02, 8'hA6, 1);
      idle(2);

      // illegal address, stray byte in IDLE
      send(8'hA3, 8'h01, 8'hA2, 0);
      tick(1'b1, 8'h55);
      idle(2);

      // timeout after header, then a byte exactly in the expiry cycle
      tick(1'b1, 8'hA4);
      idle(20);
      tick(1'b1, 8'hA4);
      idle(TO - 1);
      tick(1'b1, 8'h04);
      tick(1'b1, 8'hA0);
      idle(2);
      tick(1'b1, 8'hA8);
      tick(1'b1, 8'h01);
      idle(TO + 2);

      // overrun during ISSUE, byte coinciding with transfer, reset mid-ISSUE
      c_ready = 1'b0;
      send(8'hA8, 8'h33, 8'h9B, 0);
      tick(1'b1, 8'h11);
      idle(1);
      tick(1'b1, 8'hA4);
      c_ready = 1'b1;
      tick(1'b1, 8'h22);
      idle(1);
      c_ready = 1'b0;
      send(8'hA4, 8'h07, 8'hA3, 0);
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      c_ready = 1'b1;
      idle(3);

      // random traffic
      rand_mode = 1;
      for (int f = 0; f < 250; f++) begin
         logic [7:0] h, d, c;
         h[7:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hA;
         h[3:0] = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h4 : 4'h8) : 4'($urandom);
         d = 8'($urandom);
         c = ($urandom_range(0, 4) != 0) ? (h ^ d) : 8'($urandom);
         tick(1'b1, h); idle(($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, 3));
         tick(1'b1, d); idle($urandom_range(0, 3));
         tick(1'b1, c); idle($urandom_range(0, 4));
      end
      rand_mode = 0;
      rst = 1'b0;
      c_ready = 1'b1;
      idle(TO + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
